// File: rtl/serial_shift_pkg.sv
// serial_shift_pkg: shared state encoding, direction codes and frame sizing for serial_shift_tx.
// SERIAL_SHIFT_TX_PARITY_EN lengthens every frame by one even-parity bit.
package serial_shift_pkg;
    localparam int DATA_W = 4;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W);
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_GAP} state_t;
endpackage

// File: rtl/serial_shift_tx_sreg.sv
// serial_shift_tx_sreg: frame shift register, bit counter and registered serial lines.
// SERIAL_SHIFT_TX_PARITY_EN appends the even-parity bit to the end transmitted last.
module serial_shift_tx_sreg
    import serial_shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              dir,
    input  logic [DATA_W-1:0] din,
    output logic              r_out,
    output logic              l_out,
    output logic              last
);
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] data;
    logic [FRAME_W-1:0] data_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               dir_q;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
    assign frame = (dir == DIR_LEFT) ? {^din, din} : {din, ^din};
`else
    assign frame = din;
`endif
    assign data_nxt = (dir_q == DIR_LEFT) ? data >> 1 : data << 1;
    assign last = cnt == CNT_W'(FRAME_W - 1);
    // the serial lines are loaded with the bit for the coming cycle, so they never see a gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            cnt   <= '0;
            dir_q <= DIR_RIGHT;
            r_out <= 1'b0;
            l_out <= 1'b0;
        end else if (load) begin
            data  <= frame;
            cnt   <= '0;
            dir_q <= dir;
            r_out <= (dir == DIR_RIGHT) & frame[FRAME_W-1];
            l_out <= (dir == DIR_LEFT) & frame[0];
        end else if (shift) begin
            data  <= data_nxt;
            cnt   <= last ? '0 : cnt + 1'b1;
            r_out <= !last & (dir_q == DIR_RIGHT) & data_nxt[FRAME_W-1];
            l_out <= !last & (dir_q == DIR_LEFT) & data_nxt[0];
        end
    end
endmodule

// File: rtl/serial_shift_tx.sv
// serial_shift_tx: 4-bit parallel-to-serial transmitter feeding a left- or right-shifting receiver.
// Define SERIAL_SHIFT_TX_PARITY_EN to send an even-parity bit after the data bits.
module serial_shift_tx
    import serial_shift_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic              Ck,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] Din,
    input  logic              Din_Valid,
    input  logic              Dir,
    output logic              Din_Ready,
    output logic              R_Out,
    output logic              L_Out,
    output logic              Shift_En,
    output logic              Frame_Done,
    output logic              Busy
);
    localparam logic [3:0] GAP_LAST = 4'(GAP > 0 ? GAP - 1 : 0);
    state_t     state;
    state_t     state_nxt;
    logic [3:0] gap_cnt;
    logic       load;
    logic       last;
    assign load = Din_Valid & Din_Ready;
    serial_shift_tx_sreg u_sreg (
        .clk   (Ck),
        .rst_n (Reset_n),
        .load  (load),
        .shift (state == S_SHIFT),
        .dir   (Dir),
        .din   (Din),
        .r_out (R_Out),
        .l_out (L_Out),
        .last  (last)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = load ? S_SHIFT : S_IDLE;
            S_SHIFT: state_nxt = last ? S_DONE : S_SHIFT;
            S_DONE:  state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:   state_nxt = (gap_cnt == GAP_LAST) ? S_IDLE : S_GAP;
            default: state_nxt = S_IDLE;
        endcase
    end
    // status outputs are registered copies of the next state
    always_ff @(posedge Ck or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            Din_Ready  <= 1'b1;
            Busy       <= 1'b0;
            Shift_En   <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
            Din_Ready  <= state_nxt == S_IDLE;
            Busy       <= state_nxt != S_IDLE;
            Shift_En   <= state_nxt == S_SHIFT;
            Frame_Done <= state_nxt == S_DONE;
        end
    end
endmodule

// File: tb/tb_serial_shift_tx.sv
// tb_serial_shift_tx: two instances (GAP=0 and GAP=3) driven by shared stimulus, checked
// against a cycle-arithmetic model and a frame scoreboard.
`timescale 1ns/1ps
module tb_serial_shift_tx;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif
    localparam int GAP0 = 0;
    localparam int GAP1 = 3;

    typedef struct packed {
        logic       dir;
        logic [7:0] bits;
    } frame_t;

    logic       ck = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] din = 4'h0;
    logic       din_valid = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] din_ready, r_out, l_out, shift_en, frame_done, busy;

    int checks = 0;
    int errors = 0;
    int e = 0;
    int last_hs[2] = '{-1000, -1000};
    int nxt_ok[2] = '{0, 0};
    frame_t q0[$];
    frame_t q1[$];
    logic [7:0] acc_r[2];
    logic [7:0] acc_l[2];
    int nbits[2];

    always #5 ck = ~ck;

    serial_shift_tx #(.GAP(GAP0)) u0 (
        .Ck(ck), .Reset_n(reset_n), .Din(din), .Din_Valid(din_valid), .Dir(dir),
        .Din_Ready(din_ready[0]), .R_Out(r_out[0]), .L_Out(l_out[0]),
        .Shift_En(shift_en[0]), .Frame_Done(frame_done[0]), .Busy(busy[0])
    );
    serial_shift_tx #(.GAP(GAP1)) u1 (
        .Ck(ck), .Reset_n(reset_n), .Din(din), .Din_Valid(din_valid), .Dir(dir),
        .Din_Ready(din_ready[1]), .R_Out(r_out[1]), .L_Out(l_out[1]),
        .Shift_En(shift_en[1]), .Frame_Done(frame_done[1]), .Busy(busy[1])
    );

    // transmitted bit order, first bit in the MSB of the FLEN-bit result
    function automatic logic [7:0] frame_bits(input logic [3:0] w, input logic d);
        logic [7:0] v;
        logic       b;
        v = '0;
        for (int i = 0; i < FLEN; i++) begin
            if (i == 4) b = ^w;
            else b = d ? w[i] : w[3 - i];
            v = {v[6:0], b};
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] w, input logic d);
        @(negedge ck);
        din_valid = v;
        din = w;
        dir = d;
    endtask

    task automatic check_reset_now(input string tag);
        for (int u = 0; u < 2; u++)
            chk($sformatf("%s u%0d outputs", tag, u),
                {din_ready[u], busy[u], shift_en[u], frame_done[u], r_out[u], l_out[u]}, 6'b100000);
    endtask

    // reference model: handshakes and frame timing from plain cycle arithmetic
    always @(posedge ck) begin
        e++;
        for (int u = 0; u < 2; u++) begin
            if (!reset_n) begin
                last_hs[u] = -1000;
                nxt_ok[u] = 0;
            end else if (din_valid && e >= nxt_ok[u]) begin
                last_hs[u] = e;
                nxt_ok[u] = e + FLEN + 2 + (u == 0 ? GAP0 : GAP1);
                if (u == 0) q0.push_back('{dir: dir, bits: frame_bits(din, dir)});
                else q1.push_back('{dir: dir, bits: frame_bits(din, dir)});
            end
        end
        if (!reset_n) begin
            q0.delete();
            q1.delete();
        end
    end

    // monitor: per-cycle control checks, frame content compared on Frame_Done
    always @(negedge ck) begin
        int d;
        frame_t f;
        for (int u = 0; u < 2; u++) begin
            if (!reset_n) begin
                chk($sformatf("u%0d reset outputs", u),
                    {din_ready[u], busy[u], shift_en[u], frame_done[u], r_out[u], l_out[u]}, 6'b100000);
                acc_r[u] = '0;
                acc_l[u] = '0;
                nbits[u] = 0;
            end else begin
                d = e - last_hs[u];
                chk($sformatf("u%0d shift_en", u), shift_en[u], d >= 0 && d < FLEN);
                chk($sformatf("u%0d frame_done", u), frame_done[u], d == FLEN);
                chk($sformatf("u%0d din_ready", u), din_ready[u], e + 1 >= nxt_ok[u]);
                chk($sformatf("u%0d busy", u), busy[u], e + 1 < nxt_ok[u]);
                if (shift_en[u]) begin
                    acc_r[u] = {acc_r[u][6:0], r_out[u]};
                    acc_l[u] = {acc_l[u][6:0], l_out[u]};
                    nbits[u]++;
                end else begin
                    chk($sformatf("u%0d idle lines", u), {r_out[u], l_out[u]}, 2'b00);
                end
                if (frame_done[u]) begin
                    if ((u == 0 ? q0.size() : q1.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL u%0d frame: got unexpected Frame_Done, expected no frame at %0t", u, $time);
                    end else begin
                        f = (u == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("u%0d frame length", u), nbits[u], FLEN);
                        chk($sformatf("u%0d R_Out bits", u), acc_r[u], f.dir ? 8'h00 : f.bits);
                        chk($sformatf("u%0d L_Out bits", u), acc_l[u], f.dir ? f.bits : 8'h00);
                    end
                    acc_r[u] = '0;
                    acc_l[u] = '0;
                    nbits[u] = 0;
                end
            end
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        #1 check_reset_now("power-on reset");
        repeat (3) @(negedge ck);
        #2 reset_n = 1'b1;
        drive(1'b1, 4'b1011, 1'b0);
        repeat (14) drive(1'b0, 4'h0, 1'b0);
        drive(1'b1, 4'b1011, 1'b1);
        repeat (14) drive(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 14; i++) drive(1'b1, i < 6 ? 4'h3 : 4'hC, 1'b0);
        repeat (14) drive(1'b0, 4'h0, 1'b0);
        repeat (400) drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom));
        repeat (14) drive(1'b0, 4'h0, 1'b0);
        drive(1'b1, 4'b0110, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        @(negedge ck);
        #1 reset_n = 1'b0;
        #1 check_reset_now("mid-frame reset");
        @(posedge ck);
        @(negedge ck);
        #2 reset_n = 1'b1;
        drive(1'b1, 4'b1001, 1'b1);
        repeat (14) drive(1'b0, 4'h0, 1'b0);
        chk("u0 pending frames", q0.size(), 0);
        chk("u1 pending frames", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
